// File: rtl/eco32f_decode_sb.sv
// eco32f_decode_sb: decode-stage register scoreboard, one countdown per GPR.
// Decode bubbles on RAW/WAW against any pending in-flight writer.
//
// Ports:
//   clk, rst (async, active-low)
//   id_valid/id_stall/id_flush  decode instruction state
//   pipe_adv                    ex/mem/wb advance this cycle
//   sb_kill                     cancel all in-flight writers
//   id_rf_x/y_addr,_use         sources
//   id_rf_r_addr,_we            destination
//   id_lat                      advances until result forwardable (0 = ex fwd)
//   id_bubble, id_issue         decode control outputs
//   sb_busy                     bit n set while entry n is nonzero
//   sb_stall_cnt                bubble-cycle counter
//
// Optional feature macro: ECO32F_SB_PERF_EN enables the saturating
// bubble-cycle counter; without it sb_stall_cnt is tied to zero.

module eco32f_decode_sb #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int LAT_W   = 4,
  parameter int MAX_LAT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic             id_flush,
  input  logic             pipe_adv,
  input  logic             sb_kill,
  input  logic [AW-1:0]    id_rf_x_addr,
  input  logic             id_rf_x_use,
  input  logic [AW-1:0]    id_rf_y_addr,
  input  logic             id_rf_y_use,
  input  logic [AW-1:0]    id_rf_r_addr,
  input  logic             id_rf_r_we,
  input  logic [LAT_W-1:0] id_lat,
  output logic             id_bubble,
  output logic             id_issue,
  output logic [NREGS-1:0] sb_busy,
  output logic [31:0]      sb_stall_cnt
);

  if (MAX_LAT > (1 << LAT_W) - 1) begin : g_bad_lat
    $error("MAX_LAT does not fit in LAT_W bits");
  end

  logic [LAT_W-1:0] r_cnt [NREGS];

  logic [LAT_W-1:0] w_x_cnt;
  logic [LAT_W-1:0] w_y_cnt;
  logic [LAT_W-1:0] w_r_cnt;
  logic             w_r_nz;
  logic             w_raw;
  logic             w_waw;
  logic             w_wr;

  assign w_x_cnt = r_cnt[id_rf_x_addr];
  assign w_y_cnt = r_cnt[id_rf_y_addr];
  assign w_r_cnt = r_cnt[id_rf_r_addr];
  assign w_r_nz  = (id_rf_r_addr != '0);

  assign w_raw = (id_rf_x_use && (w_x_cnt != '0))
              || (id_rf_y_use && (w_y_cnt != '0));

  // A younger writer may not finish before an older one to the same reg.
  assign w_waw = id_rf_r_we && w_r_nz && (w_r_cnt > id_lat);

  assign id_bubble = id_valid && !id_flush && (w_raw || w_waw);
  assign id_issue  = id_valid && !id_stall && !id_flush && !id_bubble;

  // lat=0 results are covered by ex->ex forwarding: no entry needed.
  assign w_wr = id_issue && id_rf_r_we && w_r_nz && (id_lat != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NREGS; n++) r_cnt[n] <= '0;
    end else if (sb_kill) begin
      for (int n = 0; n < NREGS; n++) r_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < NREGS; n++) begin
        if (w_wr && (id_rf_r_addr == AW'(n))) begin
          r_cnt[n] <= id_lat;
        end else if (pipe_adv && (r_cnt[n] != '0)) begin
          r_cnt[n] <= r_cnt[n] - LAT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_busy
    assign sb_busy[g] = (r_cnt[g] != '0);
  end

`ifdef ECO32F_SB_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (id_bubble && (r_stall_cnt != 32'hffff_ffff)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign sb_stall_cnt = r_stall_cnt;
`else
  assign sb_stall_cnt = 32'h0;
`endif

`ifndef SYNTHESIS
  // Out-of-range latency is truncated to LAT_W bits by the port itself.
  always_ff @(posedge clk) begin
    if (rst && id_issue && id_rf_r_we && (int'(id_lat) > MAX_LAT))
      $error("eco32f_decode_sb: id_lat %0d exceeds MAX_LAT", id_lat);
  end
`endif

endmodule

// File: tb/tb_eco32f_decode_sb.sv
// tb_eco32f_decode_sb: directed scoreboard bench for eco32f_decode_sb.
// Driver pushes hand-computed expectations; monitor pops on negedge.

module tb_eco32f_decode_sb;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_stall;
  logic        id_flush;
  logic        pipe_adv;
  logic        sb_kill;
  logic [4:0]  id_rf_x_addr;
  logic        id_rf_x_use;
  logic [4:0]  id_rf_y_addr;
  logic        id_rf_y_use;
  logic [4:0]  id_rf_r_addr;
  logic        id_rf_r_we;
  logic [3:0]  id_lat;
  logic        id_bubble;
  logic        id_issue;
  logic [31:0] sb_busy;
  logic [31:0] sb_stall_cnt;

  eco32f_decode_sb dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_stall     (id_stall),
    .id_flush     (id_flush),
    .pipe_adv     (pipe_adv),
    .sb_kill      (sb_kill),
    .id_rf_x_addr (id_rf_x_addr),
    .id_rf_x_use  (id_rf_x_use),
    .id_rf_y_addr (id_rf_y_addr),
    .id_rf_y_use  (id_rf_y_use),
    .id_rf_r_addr (id_rf_r_addr),
    .id_rf_r_we   (id_rf_r_we),
    .id_lat       (id_lat),
    .id_bubble    (id_bubble),
    .id_issue     (id_issue),
    .sb_busy      (sb_busy),
    .sb_stall_cnt (sb_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        b;
    logic        i;
    logic [31:0] busy;
    logic [31:0] cnt;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_bad;
  logic [31:0] exp_cnt;

  localparam logic [31:0] B4 = 32'h0000_0010;
  localparam logic [31:0] B5 = 32'h0000_0020;
  localparam logic [31:0] B7 = 32'h0000_0080;
  localparam logic [31:0] B9 = 32'h0000_0200;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (id_bubble !== e.b || id_issue !== e.i ||
          sb_busy !== e.busy || sb_stall_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: got b=%0b i=%0b busy=%h cnt=%h, want b=%0b i=%0b busy=%h cnt=%h",
                 e.nm, id_bubble, id_issue, sb_busy, sb_stall_cnt,
                 e.b, e.i, e.busy, e.cnt);
      end
    end
  end

  task automatic vec(
    input logic v, st, fl, adv, kl,
    input logic [4:0] x, input logic xu,
    input logic [4:0] y, input logic yu,
    input logic [4:0] r, input logic we,
    input logic [3:0] lat,
    input logic eb, ei,
    input logic [31:0] ebusy,
    input string nm
  );
    exp_t e;
    @(posedge clk);
    #1;
    id_valid     = v;
    id_stall     = st;
    id_flush     = fl;
    pipe_adv     = adv;
    sb_kill      = kl;
    id_rf_x_addr = x;
    id_rf_x_use  = xu;
    id_rf_y_addr = y;
    id_rf_y_use  = yu;
    id_rf_r_addr = r;
    id_rf_r_we   = we;
    id_lat       = lat;
    e.b    = eb;
    e.i    = ei;
    e.busy = ebusy;
    e.cnt  = exp_cnt;
    e.nm   = nm;
    q.push_back(e);
`ifdef ECO32F_SB_PERF_EN
    if (eb && exp_cnt != 32'hffff_ffff) exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  task automatic direct_chk(input string nm, input logic [31:0] want);
    n_vec++;
    if (sb_busy !== want || id_bubble !== 1'b0 || sb_stall_cnt !== 32'h0) begin
      n_bad++;
      $display("FAIL %s: got busy=%h b=%0b cnt=%h, want busy=%h b=0 cnt=0",
               nm, sb_busy, id_bubble, sb_stall_cnt, want);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    exp_cnt = 32'h0;
    rst = 1'b0;
    id_valid = 0; id_stall = 0; id_flush = 0;
    pipe_adv = 0; sb_kill = 0;
    id_rf_x_addr = 0; id_rf_x_use = 0;
    id_rf_y_addr = 0; id_rf_y_use = 0;
    id_rf_r_addr = 0; id_rf_r_we = 0; id_lat = 0;

    vec(1,0,0,1,0, 5,1, 0,0, 0,0, 0, 0,1, 0, "reset");
    #6 rst = 1'b1;

    // 1: ldw r5 then dependent add
    vec(1,0,0,1,0, 2,1, 0,0, 5,1, 1, 0,1, 0,  "ldw_r5");
    vec(1,0,0,1,0, 5,1, 1,1, 6,1, 0, 1,0, B5, "add_r5_bub");
    vec(1,0,0,1,0, 5,1, 1,1, 6,1, 0, 0,1, 0,  "add_r5_iss");

    // 2: mul r7 then add, pipe moving
    vec(1,0,0,1,0, 1,1, 2,1, 7,1, 2, 0,1, 0,  "mul_r7");
    vec(1,0,0,1,0, 7,1, 0,1, 8,1, 0, 1,0, B7, "add_r7_b1");
    vec(1,0,0,1,0, 7,1, 0,1, 8,1, 0, 1,0, B7, "add_r7_b2");
    vec(1,0,0,1,0, 7,1, 0,1, 8,1, 0, 0,1, 0,  "add_r7_iss");

    // 2b: same with pipe frozen 3 cycles
    vec(1,0,0,1,0, 1,1, 2,1, 7,1, 2, 0,1, 0,  "mul_r7b");
    vec(1,0,0,0,0, 7,1, 0,1, 8,1, 0, 1,0, B7, "frz1");
    vec(1,0,0,0,0, 7,1, 0,1, 8,1, 0, 1,0, B7, "frz2");
    vec(1,0,0,0,0, 7,1, 0,1, 8,1, 0, 1,0, B7, "frz3");
    vec(1,0,0,1,0, 7,1, 0,1, 8,1, 0, 1,0, B7, "adv1");
    vec(1,0,0,1,0, 7,1, 0,1, 8,1, 0, 1,0, B7, "adv2");
    vec(1,0,0,1,0, 7,1, 0,1, 8,1, 0, 0,1, 0,  "frz_iss");

    // 3: div r9 lat10, unrelated add, then WAW addi r9
    vec(1,0,0,1,0, 1,1, 2,1, 9,1, 10, 0,1, 0,  "div_r9");
    vec(1,0,0,1,0, 1,1, 2,1, 3,1, 0,  0,1, B9, "add_r3");
    for (int k = 9; k >= 1; k--)
      vec(1,0,0,1,0, 1,1, 0,0, 9,1, 0, 1,0, B9, $sformatf("waw_%0d", k));
    vec(1,0,0,1,0, 1,1, 0,0, 9,1, 0, 0,1, 0, "waw_iss");

    // WAW boundary: equal latency issues, shorter latency bubbles
    vec(1,0,0,1,0, 1,1, 0,0, 9,1, 10, 0,1, 0,  "div_r9b");
    vec(1,0,0,1,0, 1,1, 0,0, 9,1, 10, 0,1, B9, "waw_eq");
    vec(1,0,0,1,0, 1,1, 0,0, 9,1, 9,  1,0, B9, "waw_gt");
    vec(1,0,0,1,0, 1,1, 0,0, 9,1, 9,  0,1, B9, "waw_eq2");
    vec(0,0,0,1,1, 0,0, 0,0, 0,0, 0,  0,0, B9, "kill_r9");

    // 4: kill cancels mul r7 and ignores a same-cycle issue
    vec(1,0,0,1,0, 1,1, 2,1, 7,1, 2, 0,1, 0,  "mul_r7k");
    vec(1,0,0,1,1, 1,1, 0,0, 10,1, 3, 0,1, B7, "kill_iss");
    vec(1,0,0,1,0, 7,1, 10,1, 8,1, 0, 0,1, 0,  "post_kill");

    // 5: r0 never busy
    vec(1,0,0,1,0, 2,1, 0,0, 0,1, 1, 0,1, 0, "ldw_r0");
    vec(1,0,0,1,0, 0,1, 0,1, 1,1, 0, 0,1, 0, "add_r0");

    // stall / flush with pending r4
    vec(1,0,0,1,0, 2,1, 0,0, 4,1, 3, 0,1, 0,  "ldw_r4");
    vec(1,1,0,0,0, 4,1, 0,0, 11,1, 2, 1,0, B4, "stall_haz");
    vec(1,1,0,0,0, 1,1, 0,0, 12,1, 2, 0,0, B4, "stall_ok");
    vec(1,0,1,0,0, 4,1, 4,1, 4,1, 0, 0,0, B4, "flush");
    vec(1,0,0,0,0, 4,1, 4,1, 4,1, 0, 1,0, B4, "xyr_same");

    // async reset while cnt[4]=3
    @(negedge clk);
    #1 rst = 1'b0;
    #1 direct_chk("rst_async", 32'h0);
    exp_cnt = 32'h0;
    #1 rst = 1'b1;
    vec(1,0,0,1,0, 4,1, 0,0, 0,0, 0, 0,1, 0, "post_rst");

    // saturation: 3 bubbles starting near the top
    @(negedge clk);
`ifdef ECO32F_SB_PERF_EN
    #1 force dut.r_stall_cnt = 32'hffff_fffe;
    #1 release dut.r_stall_cnt;
    exp_cnt = 32'hffff_fffe;
`endif
    vec(1,0,0,1,0, 1,1, 0,0, 7,1, 3, 0,1, 0,  "mul_sat");
    vec(1,0,0,1,0, 7,1, 0,0, 8,1, 0, 1,0, B7, "sat_b1");
    vec(1,0,0,1,0, 7,1, 0,0, 8,1, 0, 1,0, B7, "sat_b2");
    vec(1,0,0,1,0, 7,1, 0,0, 8,1, 0, 1,0, B7, "sat_b3");
    vec(1,0,0,1,0, 7,1, 0,0, 8,1, 0, 0,1, 0,  "sat_iss");
    vec(0,0,0,1,0, 0,0, 0,0, 0,0, 0, 0,0, 0,  "idle_end");

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
